reg_bus_arbiter: RTL and testbench

//  Shares the single register-file port between NUM_REQ requesters (req 0 = SPI slave, others = on-chip masters).

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/reg_bus_arbiter_if.sv | 31 +++
 rtl/reg_bus_arbiter_rr.sv | 30 +++
 rtl/reg_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_reg_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bus arbiter.
package reg_arb_pkg;

  localparam int REG_ADDR_W = 15;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} reg_arb_state_t;

  // Requester index reached by stepping off positions from base, wrapping at n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester-side and register-file-side signals of the arbiter in one bundle.
interface reg_bus_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = REG_ADDR_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [WIDTH-1:0]          rsp_rdata;
  logic                      rf_en;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_addr;
  logic [WIDTH-1:0]          rf_wdata;
  logic [WIDTH-1:0]          rf_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rf_rdata,
    output req_ready, rsp_valid, rsp_rdata, rf_en, rf_we, rf_addr, rf_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rf_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rf_en, rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/reg_bus_arbiter_rr.sv
// Combinational round-robin picker: first pending index at or after rr_ptr.
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  int idx;

  // Walk from the farthest offset back to rr_ptr so the nearest hit wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_wrap(int'(rr_ptr), k, NUM_REQ);
      if (pending[idx]) begin
        grant = IDX_W'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-file port between NUM_REQ requesters.
// Optional statistics counters are built when REG_ARB_STATS_EN is defined.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_bus_arbiter_if.slave        bus
`ifdef REG_ARB_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_REQ*16-1:0]   stat_grants,
  output logic [NUM_REQ-1:0]      stat_drop
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  reg_arb_state_t                   state, state_nxt;
  logic [NUM_REQ-1:0]               ready;
  logic [NUM_REQ-1:0]               pending;
  logic [NUM_REQ-1:0]               accept;
  logic [NUM_REQ-1:0]               buf_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0]   buf_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0]    buf_wdata;
  logic [IDX_W-1:0]                 rr_ptr, gnt, pick;
  logic                             any;

  assign pending       = ~ready;
  assign accept        = bus.req_valid & ready;
  assign bus.req_ready = ready;

  // Buffer slot i is freed only by its own RESP, which can't overlap a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= '1;
      buf_we    <= '0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          ready[i]     <= 1'b0;
          buf_we[i]    <= bus.req_we[i];
          buf_addr[i]  <= bus.req_addr[i*ADDR_W +: ADDR_W];
          buf_wdata[i] <= bus.req_wdata[i*WIDTH +: WIDTH];
        end else if (state == RESP && gnt == IDX_W'(i)) begin
          ready[i] <= 1'b1;
        end
      end
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any     (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && any) gnt <= pick;
      if (state == RESP)
        rr_ptr <= (gnt == IDX_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end

  // rf_rdata lands one cycle after rf_en, which is exactly the RESP cycle.
  always_comb begin
    bus.rf_en     = 1'b0;
    bus.rf_we     = 1'b0;
    bus.rf_addr   = '0;
    bus.rf_wdata  = '0;
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    case (state)
      ISSUE: begin
        bus.rf_en    = 1'b1;
        bus.rf_we    = buf_we[gnt];
        bus.rf_addr  = buf_addr[gnt];
        bus.rf_wdata = buf_wdata[gnt];
      end
      RESP: begin
        bus.rsp_valid[gnt] = 1'b1;
        bus.rsp_rdata      = buf_we[gnt] ? '0 : bus.rf_rdata;
      end
      default: ;
    endcase
  end

`ifdef REG_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grants_q;
  logic [NUM_REQ-1:0]       drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_q <= '0;
      drop_q   <= '0;
    end else if (stat_clr) begin
      grants_q <= '0;
      drop_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (state == RESP && gnt == IDX_W'(i) && grants_q[i] != 16'hFFFF)
          grants_q[i] <= grants_q[i] + 16'd1;
        if (bus.req_valid[i] && !ready[i])
          drop_q[i] <= 1'b1;
      end
    end
  end

  assign stat_grants = grants_q;
  assign stat_drop   = drop_q;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with two requesters.
module tb_reg_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

`ifdef REG_ARB_STATS_EN
  logic                  stat_clr = 1'b0;
  logic [NUM_REQ*16-1:0] stat_grants;
  logic [NUM_REQ-1:0]    stat_drop;
`endif

  reg_bus_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef REG_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
    .stat_drop   (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [WIDTH-1:0] d);
    bus.req_we[i]                    = we;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_wdata[i*WIDTH +: WIDTH]  = d;
  endtask

  task automatic do_reset;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rf_rdata  = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (bus.req_ready !== 2'b11) begin
      errors++; $display("FAIL reset_ready got %b exp 11", bus.req_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rf_en, bus.rf_we} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0", {bus.rsp_valid, bus.rf_en, bus.rf_we});
    end
    checks++;
    if ({bus.rsp_rdata, bus.rf_addr, bus.rf_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", bus.rsp_rdata, bus.rf_addr, bus.rf_wdata);
    end
  endtask

  task automatic test_write;
    set_req(0, 1'b1, 15'h0012, 16'h1234);
    bus.req_valid = 2'b01;
    tick;
    bus.req_valid = 2'b00;
    checks++;
    if (bus.req_ready !== 2'b10 || bus.rf_en !== 1'b0) begin
      errors++; $display("FAIL wr_t1 ready %b rf_en %b exp 10/0", bus.req_ready, bus.rf_en);
    end
    tick;
    checks++;
    if ({bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata} !== {1'b1, 1'b1, 15'h0012, 16'h1234}) begin
      errors++; $display("FAIL wr_issue en %b we %b addr %h data %h exp 1/1/0012/1234",
                         bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata);
    end
    tick;
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 16'h0 || bus.rf_en !== 1'b0) begin
      errors++; $display("FAIL wr_resp rsp %b rdata %h rf_en %b exp 01/0000/0",
                         bus.rsp_valid, bus.rsp_rdata, bus.rf_en);
    end
    tick;
    checks++;
    if (bus.req_ready !== 2'b11 || bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL wr_done ready %b rsp %b exp 11/00", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_read;
    set_req(1, 1'b0, 15'h0005, 16'h0);
    bus.rf_rdata  = 16'hBEEF;
    bus.req_valid = 2'b10;
    tick;
    bus.req_valid = 2'b00;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rd_t1_ready got %b exp 01", bus.req_ready);
    end
    tick;
    checks++;
    if ({bus.rf_en, bus.rf_we, bus.rf_addr} !== {1'b1, 1'b0, 15'h0005} || bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rd_issue en %b we %b addr %h ready %b exp 1/0/0005/01",
                         bus.rf_en, bus.rf_we, bus.rf_addr, bus.req_ready);
    end
    tick;
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 16'hBEEF || bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rd_resp rsp %b rdata %h ready %b exp 10/beef/01",
                         bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
    end
    tick;
    checks++;
    if (bus.req_ready !== 2'b11) begin
      errors++; $display("FAIL rd_done_ready got %b exp 11", bus.req_ready);
    end
  endtask

  task automatic test_simultaneous;
    int c0 = -1, c1 = -1;
    logic [ADDR_W-1:0] a2 = '0, a5 = '0;
    do_reset;
    set_req(0, 1'b1, 15'h0020, 16'hAAAA);
    set_req(1, 1'b0, 15'h0021, 16'h0);
    bus.rf_rdata  = 16'h0F0F;
    bus.req_valid = 2'b11;
    for (int c = 1; c <= 9; c++) begin
      tick;
      bus.req_valid = 2'b00;
      if (c == 2) a2 = bus.rf_addr;
      if (c == 5) a5 = bus.rf_addr;
      if (bus.rsp_valid == 2'b01 && c0 < 0) c0 = c;
      if (bus.rsp_valid == 2'b10 && c1 < 0) c1 = c;
    end
    checks++;
    if (c0 !== 3 || c1 !== 6) begin
      errors++; $display("FAIL simul_order rsp0 at %0d rsp1 at %0d exp 3/6", c0, c1);
    end
    checks++;
    if (a2 !== 15'h0020 || a5 !== 15'h0021) begin
      errors++; $display("FAIL simul_addr got %h/%h exp 0020/0021", a2, a5);
    end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int who [8];
    int when[8];
    int exp_who [5] = '{0, 1, 0, 1, 0};
    int exp_when[5] = '{3, 6, 9, 12, 15};
    set_req(0, 1'b0, 15'h0030, 16'h0);
    set_req(1, 1'b0, 15'h0031, 16'h0);
    bus.req_valid = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 12) bus.req_valid = 2'b00;
      if (bus.rsp_valid != 2'b00 && n < 8) begin
        who[n]  = (bus.rsp_valid == 2'b10) ? 1 : 0;
        when[n] = c;
        n++;
      end
    end
    checks++;
    if (n !== 5) begin
      errors++; $display("FAIL b2b_count got %0d exp 5", n);
    end
    for (int k = 0; k < 5 && k < n; k++) begin
      checks++;
      if (who[k] !== exp_who[k] || when[k] !== exp_when[k]) begin
        errors++; $display("FAIL b2b_grant%0d req %0d at %0d exp req %0d at %0d",
                           k, who[k], when[k], exp_who[k], exp_when[k]);
      end
    end
  endtask

  task automatic test_drop;
    int en_cnt = 0;
`ifdef REG_ARB_STATS_EN
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    checks++;
    if (stat_grants !== '0 || stat_drop !== '0) begin
      errors++; $display("FAIL stat_clr grants %h drop %b exp 0/0", stat_grants, stat_drop);
    end
`endif
    set_req(0, 1'b1, 15'h0033, 16'h5555);
    bus.req_valid = 2'b01;
    tick;
    checks++;
    if (bus.req_ready[0] !== 1'b0) begin
      errors++; $display("FAIL drop_busy ready0 got %b exp 0", bus.req_ready[0]);
    end
    set_req(0, 1'b1, 15'h0044, 16'h6666);
    tick;
    bus.req_valid = 2'b00;
    checks++;
    if ({bus.rf_en, bus.rf_addr, bus.rf_wdata} !== {1'b1, 15'h0033, 16'h5555}) begin
      errors++; $display("FAIL drop_issue en %b addr %h data %h exp 1/0033/5555",
                         bus.rf_en, bus.rf_addr, bus.rf_wdata);
    end
    en_cnt = 1;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (bus.rf_en) en_cnt++;
    end
    checks++;
    if (en_cnt !== 1) begin
      errors++; $display("FAIL drop_rf_en_count got %0d exp 1", en_cnt);
    end
`ifdef REG_ARB_STATS_EN
    checks++;
    if (stat_drop !== 2'b01 || stat_grants !== {16'd0, 16'd1}) begin
      errors++; $display("FAIL stat_drop drop %b grants %h exp 01/00000001", stat_drop, stat_grants);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int rsp_cnt = 0;
    set_req(1, 1'b0, 15'h0007, 16'h0);
    bus.rf_rdata  = 16'h2468;
    bus.req_valid = 2'b10;
    tick;
    bus.req_valid = 2'b00;
    tick;
    checks++;
    if (bus.rf_en !== 1'b1 || bus.rf_addr !== 15'h0007) begin
      errors++; $display("FAIL mid_issue en %b addr %h exp 1/0007", bus.rf_en, bus.rf_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 2'b11 || bus.rsp_valid !== 2'b00 || bus.rf_en !== 1'b0 ||
        bus.rf_addr !== '0 || bus.rsp_rdata !== '0) begin
      errors++; $display("FAIL mid_reset ready %b rsp %b en %b addr %h rdata %h exp 11/00/0/0/0",
                         bus.req_ready, bus.rsp_valid, bus.rf_en, bus.rf_addr, bus.rsp_rdata);
    end
    tick;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (bus.rsp_valid != 2'b00) rsp_cnt++;
    end
    checks++;
    if (rsp_cnt !== 0) begin
      errors++; $display("FAIL mid_no_rsp got %0d pulses exp 0", rsp_cnt);
    end
    set_req(1, 1'b0, 15'h0008, 16'h0);
    bus.rf_rdata  = 16'h1357;
    bus.req_valid = 2'b10;
    tick;
    bus.req_valid = 2'b00;
    tick;
    checks++;
    if (bus.rf_en !== 1'b1 || bus.rf_addr !== 15'h0008) begin
      errors++; $display("FAIL post_issue en %b addr %h exp 1/0008", bus.rf_en, bus.rf_addr);
    end
    tick;
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 16'h1357) begin
      errors++; $display("FAIL post_resp rsp %b rdata %h exp 10/1357", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_simultaneous;
    test_back_to_back;
    test_drop;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
